// File: rtl/window_5x5_gen_pkg.sv
// Shared types and window packing for the 5x5 raster-to-window stage and the edge kernel.
package window_5x5_gen_pkg;

    typedef logic [7:0] pix_t;

    localparam int PIX_BITS  = 8;
    localparam int WIN_DIM   = 5;
    localparam int WIN_BITS  = WIN_DIM * WIN_DIM * PIX_BITS;
    localparam int NUM_LINES = WIN_DIM - 1;

    // One vertical slice of the window, index 0 = oldest (top) row.
    typedef pix_t col_t [WIN_DIM];

    // Bit offset of window element (row r, column c) inside the packed 200-bit window.
    function automatic int win_idx(input int r, input int c);
        return (r * WIN_DIM + c) * PIX_BITS;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of pixel storage: combinational read and synchronous write at a shared address.
module line_buffer
    import window_5x5_gen_pkg::*;
#(
    parameter int IMG_WIDTH = 640,
    parameter int AW        = $clog2(IMG_WIDTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  pix_t          i_wdata,
    output pix_t          o_rdata
);

    // NOTE: the storage array has no reset; every location is rewritten before it is read for output.
    pix_t r_mem [IMG_WIDTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // The read sees the old contents during the write cycle, giving read-before-write.
    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/window_5x5_gen.sv
// Raster-to-window stage: four cascaded line buffers feed a 5x5 shift window with a one-entry output register.
module window_5x5_gen
    import window_5x5_gen_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                clk,
    input  logic                rst,
    input  pix_t                in_pixel,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [WIN_BITS-1:0] win_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0]       r_col;
    logic [RW-1:0]       r_row;
    logic [WIN_BITS-1:0] r_win;
    logic [WIN_BITS-1:0] w_win_next;
    pix_t                w_lb_rd [NUM_LINES];
    pix_t                w_lb_wr [NUM_LINES];
    col_t                w_col;
    logic                w_xfer_in;
    logic                w_col_end;
    logic                w_row_end;
    logic                w_emit;
    logic                w_last;

    assign in_ready  = !out_valid || out_ready;
    assign w_xfer_in = in_valid && in_ready;
    assign w_col_end = (r_col == CW'(IMG_WIDTH - 1));
    assign w_row_end = (r_row == RW'(IMG_HEIGHT - 1));
    assign w_emit    = w_xfer_in && (r_row >= RW'(WIN_DIM - 1)) && (r_col >= CW'(WIN_DIM - 1));
    assign w_last    = w_col_end && w_row_end;

    // Raster position of the pixel currently presented on the input.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_xfer_in) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Line k+1 receives what line k held at this column: each stored pixel ages by one line.
    always_comb begin
        // NOTE: every combinational output is assigned a default first so no latch can be inferred.
        w_lb_wr[0] = in_pixel;
        for (int k = 1; k < NUM_LINES; k++) begin
            w_lb_wr[k] = w_lb_rd[k-1];
        end
    end

    for (genvar k = 0; k < NUM_LINES; k++) begin : g_lines
        line_buffer #(
            .IMG_WIDTH (IMG_WIDTH),
            .AW        (CW)
        ) u_line_buffer (
            .clk     (clk),
            .i_we    (w_xfer_in),
            .i_addr  (r_col),
            .i_wdata (w_lb_wr[k]),
            .o_rdata (w_lb_rd[k])
        );
    end

    always_comb begin
        for (int r = 0; r < NUM_LINES; r++) begin
            w_col[r] = w_lb_rd[NUM_LINES-1-r];
        end
        w_col[WIN_DIM-1] = in_pixel;
    end

    // Window after this transfer: columns move toward c=0 and the new column lands at c=4.
    always_comb begin
        w_win_next = r_win;
        for (int r = 0; r < WIN_DIM; r++) begin
            for (int c = 0; c < WIN_DIM - 1; c++) begin
                w_win_next[win_idx(r, c) +: PIX_BITS] = r_win[win_idx(r, c + 1) +: PIX_BITS];
            end
            w_win_next[win_idx(r, WIN_DIM - 1) +: PIX_BITS] = w_col[r];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win <= '0;
        end else if (w_xfer_in) begin
            r_win <= w_win_next;
        end
    end

    // A fresh emit takes priority over clearing, so back-to-back windows keep out_valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_out   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (w_emit) begin
            win_out   <= w_win_next;
            out_valid <= 1'b1;
            out_last  <= w_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_window_5x5_gen.sv
// Directed bench for window_5x5_gen on an 8x6 image: ramp, backpressure, gaps, back-to-back frames, reset.
module tb_window_5x5_gen;
    import window_5x5_gen_pkg::*;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int NWIN = (W - 4) * (H - 4);

    logic                clk = 1'b0;
    logic                rst;
    pix_t                in_pixel;
    logic                in_valid;
    logic                in_ready;
    logic [WIN_BITS-1:0] win_out;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;

    int checks = 0;
    int errors = 0;

    logic [WIN_BITS-1:0] q_win [$];
    logic                q_last [$];

    always #5 clk = ~clk;

    window_5x5_gen #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_pixel  (in_pixel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .win_out   (win_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    // Record every accepted output window; sampled mid-cycle, ahead of the transferring edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            q_win.push_back(win_out);
            q_last.push_back(out_last);
        end
    end

    task automatic check(input string tag, input logic [WIN_BITS-1:0] obs, input logic [WIN_BITS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 0: ramp A, 1: ramp B, 2: horizontal step, 3: flat
    function automatic pix_t pix(input int pat, input int r, input int c);
        case (pat)
            0:       return pix_t'(r * 16 + c);
            1:       return pix_t'(128 + r * 16 + c);
            2:       return (c >= 4) ? 8'd200 : 8'd0;
            default: return 8'h33;
        endcase
    endfunction

    // Window whose bottom-right pixel is (rr, cc): element (r, c) = image(rr-4+r, cc-4+c).
    function automatic logic [WIN_BITS-1:0] exp_win(input int pat, input int rr, input int cc);
        logic [WIN_BITS-1:0] w;
        w = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                w[(r * 5 + c) * 8 +: 8] = pix(pat, rr - 4 + r, cc - 4 + c);
            end
        end
        return w;
    endfunction

    task automatic send_pixel(input pix_t p);
        logic acc;
        int   n;
        in_valid = 1'b1;
        in_pixel = p;
        n        = 0;
        acc      = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        check("accept_timeout", {{(WIN_BITS-1){1'b0}}, acc}, 1);
    endtask

    task automatic gap_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic stall_after_first(input int pat);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pixel  = pix(pat, 4, 5);
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", {{(WIN_BITS-1){1'b0}}, in_ready}, 0);
            check("bp_out_valid", {{(WIN_BITS-1){1'b0}}, out_valid}, 1);
            check("bp_win_hold", win_out, exp_win(pat, 4, 4));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
    endtask

    task automatic run_frame(input int pat, input int max_gap, input bit stall);
        q_win.delete();
        q_last.delete();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                gap_cycles($urandom_range(max_gap, 0));
                send_pixel(pix(pat, r, c));
                if (stall && r == 4 && c == 4) stall_after_first(pat);
            end
        end
        gap_cycles(3);
    endtask

    task automatic compare_frame(input int pat, input string tag);
        int idx;
        check({tag, "_count"}, WIN_BITS'(q_win.size()), WIN_BITS'(NWIN));
        idx = 0;
        for (int r = 4; r < H; r++) begin
            for (int c = 4; c < W; c++) begin
                if (idx < q_win.size()) begin
                    check({tag, "_win"}, q_win[idx], exp_win(pat, r, c));
                    check({tag, "_last"}, {{(WIN_BITS-1){1'b0}}, q_last[idx]},
                          (r == H - 1 && c == W - 1) ? 1 : 0);
                end
                idx++;
            end
        end
    endtask

    initial begin
        logic [WIN_BITS-1:0] w;
        pix_t                b;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_pixel  = '0;
        out_ready = 1'b1;
        gap_cycles(2);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {{(WIN_BITS-1){1'b0}}, out_valid}, 0);
        check("rst_out_last", {{(WIN_BITS-1){1'b0}}, out_last}, 0);
        check("rst_win_out", win_out, '0);
        check("rst_in_ready", {{(WIN_BITS-1){1'b0}}, in_ready}, 1);
        @(posedge clk);
        #1;

        // Plain ramp with hand-computed corner values.
        run_frame(0, 0, 0);
        compare_frame(0, "ramp");
        w = (q_win.size() > 0) ? q_win[0] : '0;
        b = w[7:0];
        check("ramp_first_lo", WIN_BITS'(b), WIN_BITS'(8'h00));
        b = w[199:192];
        check("ramp_first_hi", WIN_BITS'(b), WIN_BITS'(8'h44));
        w = (q_win.size() > 0) ? q_win[q_win.size() - 1] : '0;
        b = w[199:192];
        check("ramp_last_hi", WIN_BITS'(b), WIN_BITS'(8'h57));
        check("ramp_last_flag", {{(WIN_BITS-1){1'b0}}, (q_last.size() > 0) ? q_last[q_last.size() - 1] : 1'b0}, 1);

        run_frame(0, 0, 1);
        compare_frame(0, "bp");

        run_frame(0, 3, 0);
        compare_frame(0, "gap");

        // Back-to-back frames without reset: frame B must not show frame A values.
        run_frame(0, 0, 0);
        run_frame(1, 0, 0);
        compare_frame(1, "frame2");

        // Partial frame of ramp B, reset while (3,5) is presented, then a clean ramp A frame.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r < 3 || c < 5) send_pixel(pix(1, r, c));
            end
        end
        in_valid = 1'b1;
        in_pixel = pix(1, 3, 5);
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", {{(WIN_BITS-1){1'b0}}, out_valid}, 0);
        check("midrst_win_out", win_out, '0);
        @(posedge clk);
        #1;
        run_frame(0, 0, 0);
        compare_frame(0, "midrst");
        check("midrst_first", (q_win.size() > 0) ? q_win[0] : '0, exp_win(0, 4, 4));

        run_frame(2, 1, 0);
        compare_frame(2, "step");
        run_frame(3, 0, 0);
        compare_frame(3, "flat");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
